mac_ram_arbiter: RTL and testbench
==================================

Name: mac_ram_arbiter

Overview:
Shares the single SDRAM controller port between the 68000 bus cycle and the video/framebuffer fetch requester. It turns the CPU's address-strobe cycle into a one-shot memory request and generates DTACK. It grants video fetches with priority, bounded by an anti-starvation limit. It sits between the CPU address decode/overlay logic and the sdram controller instance in the top level.

Parameters:
ADDR_W, 22, word-address width on all address ports
MAX_VID_RUN, 4, consecutive video grants allowed while a CPU request waits (1..15)
TIMEOUT_CYC, 255, cycles waited for mem_ack before bus error (only with ARB_TIMEOUT_EN)

Ports:
clk  in  1  single system clock (clk_cpu domain)
reset  in  1  synchronous, active-high
cpu_as_n  in  1  68000 address strobe, active low
cpu_cs  in  1  decoded RAM select, qualified by cpu_as_n
cpu_rw  in  1  1=read, 0=write
cpu_uds_n  in  1  upper byte strobe, active low
cpu_lds_n  in  1  lower byte strobe, active low
cpu_addr  in  ADDR_W  word address, already offset-corrected
cpu_din  in  16  CPU write data
cpu_dout  out  16  read data to CPU, registered
cpu_dtack_n  out  1  data transfer acknowledge, active low
cpu_berr_n  out  1  bus error, active low
vid_req  in  1  video fetch request, level, held until vid_ack
vid_addr  in  ADDR_W  video word address
vid_ack  out  1  one-cycle pulse, vid_dout valid
vid_dout  out  16  video read data, registered
mem_req  out  1  request to sdram controller, held until mem_ack
mem_we  out  1  1=write
mem_be  out  2  byte enables {upper,lower}
mem_addr  out  ADDR_W  word address
mem_wdata  out  16  write data
mem_ack  in  1  one-cycle completion pulse
mem_rdata  in  16  read data, valid with mem_ack

Behaviour:
- Reset values: cpu_dout=0, cpu_dtack_n=1, cpu_berr_n=1, vid_ack=0, vid_dout=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0; run counter=0; cpu_pending=0; cycle_served=0; state=IDLE.
- CPU capture: cpu_pending sets when cpu_as_n=0, cpu_cs=1, cycle_served=0 and cpu_pending=0. On set, latch addr, rw, be={~uds_n,~lds_n}, din. cycle_served clears only when cpu_as_n=1; this guarantees one memory access per AS cycle.
- States:
  IDLE: choose a winner in the same cycle. Video wins if vid_req=1 and (cpu_pending=0 or run<MAX_VID_RUN). Otherwise CPU wins if cpu_pending=1. The choice is registered. In the next cycle mem_req=1 and the mem_* fields are driven. Video always reads (mem_we=0, mem_be=2'b11).
  VID_ACC: on mem_ack, vid_dout<=mem_rdata and vid_ack=1 for one cycle. If cpu_pending=1, run<=run+1 (saturating at 15). Go to IDLE.
  CPU_ACC: on mem_ack, cpu_dout<=mem_rdata (reads only), cpu_dtack_n<=0, cpu_pending<=0, cycle_served<=1, run<=0. Go to CPU_HOLD.
  CPU_HOLD: hold dtack low; when cpu_as_n=1, set cpu_dtack_n<=1 and go to IDLE.
- mem_req drops in the cycle after mem_ack. The minimum gap between requests is 1 idle cycle.
- A request arriving with mem_ack in the same cycle is evaluated in the next IDLE.
- If vid_req and CPU capture arrive in the same cycle with run=0, video is granted first.
- If vid_req drops before grant, no access is made. After grant, the access completes regardless of vid_req.
- If cpu_as_n rises during CPU_ACC (aborted cycle), the memory access still completes, dtack is not asserted, and the state goes to IDLE.
- Reset mid-access: all outputs and state return to reset values immediately. A late mem_ack while in IDLE is ignored.
- Worst-case CPU latency: MAX_VID_RUN video accesses plus one CPU access.

Optional Feature:
ARB_TIMEOUT_EN
- Defined: a counter runs while mem_req=1. Reaching TIMEOUT_CYC without mem_ack drops mem_req. For a CPU access this drives cpu_berr_n=0 (held until cpu_as_n=1, cycle then marked served). For a video access it pulses vid_ack with vid_dout=16'hFFFF. State returns to IDLE (CPU: via CPU_HOLD for the berr hold).
- Undefined: no counter, cpu_berr_n tied 1, waits indefinitely for mem_ack.

Test Plan:
- CPU read addr 22'h000100, mem_rdata=16'h4AFC after 3 cycles -> single mem_req with mem_we=0, be=2'b11; cpu_dout=16'h4AFC; dtack_n low until as_n high; no second request while as_n stays low.
- CPU write, uds_n=0, lds_n=1, din=16'hA5xx -> mem_we=1, mem_be=2'b10, mem_wdata=16'hA5xx; dtack_n follows mem_ack.
- vid_req held continuously, CPU pending, MAX_VID_RUN=4 -> exactly 4 vid_acks, then the CPU access, then video resumes; run resets to 0.
- vid_req and CPU capture in the same cycle -> video granted first, CPU second; both complete with correct data 16'h1234/16'h5678.
- Reset asserted during CPU_ACC with mem_ack pending -> next cycle all outputs at reset values; a late mem_ack does not produce dtack; a fresh AS cycle works normally.
- ARB_TIMEOUT_EN, TIMEOUT_CYC=8, mem_ack never arrives -> mem_req drops after 8 cycles; cpu_berr_n=0 until as_n high; dtack_n stays 1.

Source files
------------

// File: rtl/mac_ram_arbiter_if.sv
// SDRAM controller request port shared by the CPU and video requesters.
// master = arbiter side, slave = sdram controller side.
interface mac_ram_arbiter_if #(
    parameter int unsigned ADDR_W = 22
) ();
    logic              mem_req;
    logic              mem_we;
    logic [1:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              mem_ack;
    logic [15:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mac_ram_arbiter.sv
// Arbitrates the SDRAM port between 68000 AS cycles (one access per AS) and video fetches.
// Define ARB_TIMEOUT_EN to add a mem_ack watchdog (CPU bus error / dummy video data).
module mac_ram_arbiter #(
    parameter int unsigned ADDR_W      = 22,
    parameter int unsigned MAX_VID_RUN = 4,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_as_n,
    input  logic              cpu_cs,
    input  logic              cpu_rw,
    input  logic              cpu_uds_n,
    input  logic              cpu_lds_n,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [15:0]       cpu_din,
    output logic [15:0]       cpu_dout,
    output logic              cpu_dtack_n,
    output logic              cpu_berr_n,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic [15:0]       vid_dout,
    mac_ram_arbiter_if.master mem
);
    typedef enum logic [1:0] {IDLE, VID_ACC, CPU_ACC, CPU_HOLD} state_t;

    state_t            state_q, state_d;
    logic              pending_q, pending_d, served_q, served_d, abort_q, abort_d;
    logic [ADDR_W-1:0] c_addr_q, c_addr_d;
    logic              c_rw_q, c_rw_d;
    logic [1:0]        c_be_q, c_be_d;
    logic [15:0]       c_din_q, c_din_d;
    logic [3:0]        run_q, run_d;
    logic [15:0]       cpu_dout_q, cpu_dout_d, vid_dout_q, vid_dout_d;
    logic              dtack_n_q, dtack_n_d, vid_ack_q, vid_ack_d;
    logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [1:0]        mem_be_q, mem_be_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [15:0]       mem_wdata_q, mem_wdata_d;
    logic              capture, vid_win, acc_done, cpu_ok, tmo_hit;

    assign capture  = ~cpu_as_n & cpu_cs & ~served_q & ~pending_q;
    assign vid_win  = vid_req & (~pending_q | (run_q < 4'(MAX_VID_RUN)));
    assign acc_done = mem.mem_ack | tmo_hit;
    // CPU cycle still live: AS never released since the access was granted
    assign cpu_ok   = ~cpu_as_n & ~abort_q;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             berr_n_q, berr_n_d;

    always_comb begin
        tmo_d = mem_req_q ? tmo_q + 1'b1 : '0;
    end
    assign tmo_hit    = mem_req_q & ~mem.mem_ack & (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
    assign cpu_berr_n = berr_n_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_q    <= '0;
            berr_n_q <= 1'b1;
        end else begin
            tmo_q    <= tmo_d;
            berr_n_q <= berr_n_d;
        end
    end
`else
    assign tmo_hit    = 1'b0;
    assign cpu_berr_n = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (vid_win)        state_d = VID_ACC;
                else if (pending_q) state_d = CPU_ACC;
            end
            VID_ACC:  if (acc_done) state_d = IDLE;
            CPU_ACC:  if (acc_done) state_d = cpu_ok ? CPU_HOLD : IDLE;
            CPU_HOLD: if (cpu_as_n) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        pending_d   = pending_q;
        served_d    = served_q;
        abort_d     = abort_q;
        c_addr_d    = c_addr_q;
        c_rw_d      = c_rw_q;
        c_be_d      = c_be_q;
        c_din_d     = c_din_q;
        run_d       = run_q;
        cpu_dout_d  = cpu_dout_q;
        vid_dout_d  = vid_dout_q;
        dtack_n_d   = dtack_n_q;
        vid_ack_d   = 1'b0;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef ARB_TIMEOUT_EN
        berr_n_d    = berr_n_q;
`endif
        if (capture) begin
            pending_d = 1'b1;
            c_addr_d  = cpu_addr;
            c_rw_d    = cpu_rw;
            c_be_d    = {~cpu_uds_n, ~cpu_lds_n};
            c_din_d   = cpu_din;
        end
        if (cpu_as_n) served_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (vid_win) begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_be_d   = 2'b11;
                    mem_addr_d = vid_addr;
                end else if (pending_q) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = ~c_rw_q;
                    mem_be_d    = c_be_q;
                    mem_addr_d  = c_addr_q;
                    mem_wdata_d = c_din_q;
                    abort_d     = 1'b0;
                end
            end
            VID_ACC: begin
                if (acc_done) begin
                    mem_req_d  = 1'b0;
                    vid_ack_d  = 1'b1;
                    vid_dout_d = mem.mem_ack ? mem.mem_rdata : 16'hFFFF;
                    if (pending_q && run_q != 4'hF) run_d = run_q + 4'd1;
                end
            end
            CPU_ACC: begin
                if (acc_done) begin
                    mem_req_d = 1'b0;
                    pending_d = 1'b0;
                    run_d     = '0;
                    served_d  = cpu_ok;
                    abort_d   = 1'b0;
                    if (mem.mem_ack) begin
                        if (c_rw_q) cpu_dout_d = mem.mem_rdata;
                        dtack_n_d = ~cpu_ok;
                    end
`ifdef ARB_TIMEOUT_EN
                    else berr_n_d = ~cpu_ok;
`endif
                end else if (cpu_as_n) begin
                    abort_d = 1'b1;
                end
            end
            CPU_HOLD: begin
                if (cpu_as_n) begin
                    dtack_n_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    berr_n_d  = 1'b1;
`endif
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q   <= 1'b0;
            served_q    <= 1'b0;
            abort_q     <= 1'b0;
            c_addr_q    <= '0;
            c_rw_q      <= 1'b0;
            c_be_q      <= '0;
            c_din_q     <= '0;
            run_q       <= '0;
            cpu_dout_q  <= '0;
            vid_dout_q  <= '0;
            dtack_n_q   <= 1'b1;
            vid_ack_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            pending_q   <= pending_d;
            served_q    <= served_d;
            abort_q     <= abort_d;
            c_addr_q    <= c_addr_d;
            c_rw_q      <= c_rw_d;
            c_be_q      <= c_be_d;
            c_din_q     <= c_din_d;
            run_q       <= run_d;
            cpu_dout_q  <= cpu_dout_d;
            vid_dout_q  <= vid_dout_d;
            dtack_n_q   <= dtack_n_d;
            vid_ack_q   <= vid_ack_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign cpu_dout      = cpu_dout_q;
    assign cpu_dtack_n   = dtack_n_q;
    assign vid_ack       = vid_ack_q;
    assign vid_dout      = vid_dout_q;
    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_be    = mem_be_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_mac_ram_arbiter.sv
// Self-checking bench for mac_ram_arbiter: SDRAM responder model, request scoreboard,
// one task per scenario. Define ARB_TIMEOUT_EN to exercise the watchdog build.
module tb_mac_ram_arbiter;
    localparam int unsigned AW = 22;

    typedef struct packed {
        logic          we;
        logic [1:0]    be;
        logic [AW-1:0] addr;
        logic [15:0]   wdata;
    } mreq_t;

    logic          clk = 1'b0;
    logic          reset, cpu_as_n, cpu_cs, cpu_rw, cpu_uds_n, cpu_lds_n;
    logic [AW-1:0] cpu_addr, vid_addr;
    logic [15:0]   cpu_din, cpu_dout, vid_dout;
    logic          cpu_dtack_n, cpu_berr_n, vid_req, vid_ack;

    mac_ram_arbiter_if #(.ADDR_W(AW)) mif ();

    mac_ram_arbiter #(.ADDR_W(AW), .MAX_VID_RUN(4), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .reset(reset),
        .cpu_as_n(cpu_as_n), .cpu_cs(cpu_cs), .cpu_rw(cpu_rw),
        .cpu_uds_n(cpu_uds_n), .cpu_lds_n(cpu_lds_n),
        .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
        .cpu_dtack_n(cpu_dtack_n), .cpu_berr_n(cpu_berr_n),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_dout(vid_dout),
        .mem(mif)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    mreq_t       exp_q[$];
    mreq_t       obs_q[$];
    logic [15:0] resp_data_q[$];
    logic [15:0] vid_obs_q[$];
    bit          resp_en = 1'b0;
    int          resp_lat = 2;
    int          resp_cnt = 0;
    logic [15:0] resp_val = '0;
    int          inject_cnt = 0;
    int          inject_seen = 0;
    int          last_ack_cyc = 0;

    function automatic logic [15:0] hash_data(input logic [AW-1:0] a);
        return a[15:0] ^ 16'hC3C3;
    endfunction

    always @(posedge clk) cyc++;

    // SDRAM responder: logs each new request, answers after resp_lat cycles
    always @(negedge clk) begin
        if (mif.mem_ack !== 1'b0) begin
            mif.mem_ack = 1'b0;
        end else if (inject_cnt != inject_seen) begin
            inject_seen   = inject_cnt;
            mif.mem_ack   = 1'b1;
            mif.mem_rdata = 16'hBEEF;
        end else if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                mif.mem_ack   = 1'b1;
                mif.mem_rdata = resp_val;
                last_ack_cyc  = cyc;
            end
        end else if (resp_en && mif.mem_req === 1'b1) begin
            obs_q.push_back({mif.mem_we, mif.mem_be, mif.mem_addr,
                             mif.mem_we ? mif.mem_wdata : 16'h0000});
            resp_val = (resp_data_q.size() > 0) ? resp_data_q.pop_front() : hash_data(mif.mem_addr);
            resp_cnt = resp_lat;
        end
        if (vid_ack === 1'b1) vid_obs_q.push_back(vid_dout);
    end

    initial begin
        #300000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    task automatic cpu_start(input logic [AW-1:0] a, input logic rw, input logic uds_n,
                             input logic lds_n, input logic [15:0] din);
        cpu_addr  = a;
        cpu_rw    = rw;
        cpu_uds_n = uds_n;
        cpu_lds_n = lds_n;
        cpu_din   = din;
        cpu_cs    = 1'b1;
        cpu_as_n  = 1'b0;
    endtask

    task automatic cpu_end();
        cpu_as_n  = 1'b1;
        cpu_cs    = 1'b0;
        cpu_uds_n = 1'b1;
        cpu_lds_n = 1'b1;
    endtask

    task automatic wait_dtack(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (cpu_dtack_n === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_vid_ack(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (vid_ack === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({cpu_dout, cpu_dtack_n, cpu_berr_n, vid_ack, vid_dout} !== {16'h0, 1'b1, 1'b1, 1'b0, 16'h0}) begin
            failures++;
            $display("FAIL reset_cpu_vid got=%h exp=%h", {cpu_dout, cpu_dtack_n, cpu_berr_n, vid_ack, vid_dout},
                     {16'h0, 1'b1, 1'b1, 1'b0, 16'h0});
        end
        checks++;
        if ({mif.mem_req, mif.mem_we, mif.mem_be, mif.mem_addr, mif.mem_wdata} !== '0) begin
            failures++;
            $display("FAIL reset_mem got=%h exp=0", {mif.mem_req, mif.mem_we, mif.mem_be, mif.mem_addr, mif.mem_wdata});
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_cpu_read();
        bit    ok;
        mreq_t e, o;
        obs_q.delete();
        resp_lat = 3;
        resp_en  = 1'b1;
        resp_data_q.push_back(16'h4AFC);
        exp_q.push_back({1'b0, 2'b11, 22'h000100, 16'h0000});
        cpu_start(22'h000100, 1'b1, 1'b0, 1'b0, 16'h0000);
        wait_dtack(40, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL read_dtack got=timeout exp=dtack_n=0"); end
        checks++;
        if (cpu_dout !== 16'h4AFC) begin failures++; $display("FAIL read_data got=%h exp=4afc", cpu_dout); end
        repeat (8) @(negedge clk);
        checks++;
        if (cpu_dtack_n !== 1'b0) begin failures++; $display("FAIL read_dtack_hold got=%b exp=0", cpu_dtack_n); end
        checks++;
        if (obs_q.size() != 1) begin failures++; $display("FAIL read_single_req got=%0d exp=1", obs_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("FAIL read_memreq got=none exp=%h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin failures++; $display("FAIL read_memreq got=%h exp=%h", o, e); end
            end
        end
        cpu_end();
        @(negedge clk);
        checks++;
        if (cpu_dtack_n !== 1'b1) begin failures++; $display("FAIL read_dtack_release got=%b exp=1", cpu_dtack_n); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_cpu_write();
        bit    ok;
        mreq_t e, o;
        obs_q.delete();
        resp_lat = 2;
        exp_q.push_back({1'b1, 2'b10, 22'h0002A5, 16'hA55A});
        cpu_start(22'h0002A5, 1'b0, 1'b0, 1'b1, 16'hA55A);
        wait_dtack(40, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL write_dtack got=timeout exp=dtack_n=0"); end
        checks++;
        if (cyc - last_ack_cyc != 1) begin
            failures++; $display("FAIL write_dtack_after_ack got=%0d exp=1 cycles", cyc - last_ack_cyc);
        end
        checks++;
        if (cpu_dout !== 16'h4AFC) begin failures++; $display("FAIL write_keeps_dout got=%h exp=4afc", cpu_dout); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("FAIL write_memreq got=none exp=%h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin failures++; $display("FAIL write_memreq got=%h exp=%h", o, e); end
            end
        end
        cpu_end();
        @(negedge clk);
        checks++;
        if (cpu_dtack_n !== 1'b1) begin failures++; $display("FAIL write_dtack_release got=%b exp=1", cpu_dtack_n); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_vid_starvation();
        bit          ok;
        int          n;
        logic [15:0] v;
        logic [15:0] exp_v;
        obs_q.delete();
        vid_obs_q.delete();
        resp_lat = 2;
        vid_addr = 22'h3F0010;
        exp_v    = hash_data(22'h3F0010);
        vid_req  = 1'b1;
        wait_vid_ack(40, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL starve_first_vid got=timeout exp=vid_ack"); end
        for (int it = 0; it < 2; it++) begin
            cpu_start(22'h000200 + AW'(it), 1'b1, 1'b0, 1'b0, 16'h0000);
            n = 0;
            for (int i = 0; i < 200 && cpu_dtack_n !== 1'b0; i++) begin
                @(negedge clk);
                if (vid_ack === 1'b1) n++;
            end
            checks++;
            if (n != 4) begin failures++; $display("FAIL starve_vid_run[%0d] got=%0d exp=4", it, n); end
            checks++;
            if (cpu_dtack_n !== 1'b0 || cpu_dout !== hash_data(22'h000200 + AW'(it))) begin
                failures++;
                $display("FAIL starve_cpu_access[%0d] got=%b/%h exp=0/%h", it, cpu_dtack_n, cpu_dout,
                         hash_data(22'h000200 + AW'(it)));
            end
            cpu_end();
            n = 0;
            for (int i = 0; i < 60 && n < 2; i++) begin
                @(negedge clk);
                if (vid_ack === 1'b1) n++;
            end
            checks++;
            if (n != 2) begin failures++; $display("FAIL starve_vid_resume[%0d] got=%0d exp=2", it, n); end
        end
        vid_req = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (mif.mem_req !== 1'b0) begin failures++; $display("FAIL starve_drain got=%b exp=0", mif.mem_req); end
        checks++;
        if (vid_obs_q.size() < 12) begin failures++; $display("FAIL starve_vid_count got=%0d exp>=12", vid_obs_q.size()); end
        while (vid_obs_q.size() > 0) begin
            v = vid_obs_q.pop_front();
            checks++;
            if (v !== exp_v) begin failures++; $display("FAIL starve_vid_data got=%h exp=%h", v, exp_v); end
        end
    endtask

    task automatic test_same_cycle();
        bit    ok;
        mreq_t e, o;
        obs_q.delete();
        vid_obs_q.delete();
        resp_lat = 2;
        resp_data_q.push_back(16'h1234);
        resp_data_q.push_back(16'h5678);
        exp_q.push_back({1'b0, 2'b11, 22'h100040, 16'h0000});
        exp_q.push_back({1'b0, 2'b11, 22'h000300, 16'h0000});
        vid_addr = 22'h100040;
        vid_req  = 1'b1;
        cpu_start(22'h000300, 1'b1, 1'b0, 1'b0, 16'h0000);
        wait_vid_ack(40, ok);
        vid_req = 1'b0;
        checks++;
        if (!ok || vid_dout !== 16'h1234) begin
            failures++; $display("FAIL same_vid_first got=%b/%h exp=1/1234", ok, vid_dout);
        end
        wait_dtack(40, ok);
        checks++;
        if (!ok || cpu_dout !== 16'h5678) begin
            failures++; $display("FAIL same_cpu_second got=%b/%h exp=1/5678", ok, cpu_dout);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("FAIL same_order got=none exp=%h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin failures++; $display("FAIL same_order got=%h exp=%h", o, e); end
            end
        end
        cpu_end();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_access();
        bit    ok;
        bit    bad;
        mreq_t e, o;
        obs_q.delete();
        resp_en = 1'b0;
        cpu_start(22'h000400, 1'b1, 1'b0, 1'b0, 16'h0000);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mif.mem_req === 1'b1) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL rstmid_req got=timeout exp=mem_req"); end
        @(negedge clk);
        reset = 1'b1;
        cpu_end();
        @(negedge clk);
        checks++;
        if ({mif.mem_req, mif.mem_we, mif.mem_be, mif.mem_addr, mif.mem_wdata} !== '0) begin
            failures++;
            $display("FAIL rstmid_mem got=%h exp=0", {mif.mem_req, mif.mem_we, mif.mem_be, mif.mem_addr, mif.mem_wdata});
        end
        checks++;
        if ({cpu_dout, cpu_dtack_n, cpu_berr_n, vid_ack, vid_dout} !== {16'h0, 1'b1, 1'b1, 1'b0, 16'h0}) begin
            failures++;
            $display("FAIL rstmid_cpu got=%h exp=%h", {cpu_dout, cpu_dtack_n, cpu_berr_n, vid_ack, vid_dout},
                     {16'h0, 1'b1, 1'b1, 1'b0, 16'h0});
        end
        reset = 1'b0;
        @(negedge clk);
        inject_cnt++;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (cpu_dtack_n !== 1'b1 || mif.mem_req !== 1'b0 || cpu_dout !== 16'h0 || vid_ack !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin failures++; $display("FAIL rstmid_late_ack got=response exp=ignored"); end
        resp_en  = 1'b1;
        resp_lat = 1;
        resp_data_q.push_back(16'h7777);
        exp_q.push_back({1'b0, 2'b01, 22'h000401, 16'h0000});
        cpu_start(22'h000401, 1'b1, 1'b1, 1'b0, 16'h0000);
        wait_dtack(40, ok);
        checks++;
        if (!ok || cpu_dout !== 16'h7777) begin
            failures++; $display("FAIL rstmid_fresh got=%b/%h exp=1/7777", ok, cpu_dout);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++; $display("FAIL rstmid_memreq got=none exp=%h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin failures++; $display("FAIL rstmid_memreq got=%h exp=%h", o, e); end
            end
        end
        cpu_end();
        repeat (3) @(negedge clk);
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        bit bad;
        resp_en = 1'b0;
        cpu_start(22'h000500, 1'b1, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 20 && mif.mem_req !== 1'b1; i++) @(negedge clk);
        n = 0;
        while (mif.mem_req === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 8) begin failures++; $display("FAIL tmo_req_cycles got=%0d exp=8", n); end
        checks++;
        if (cpu_berr_n !== 1'b0 || cpu_dtack_n !== 1'b1) begin
            failures++; $display("FAIL tmo_berr got=%b/%b exp=0/1", cpu_berr_n, cpu_dtack_n);
        end
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (cpu_berr_n !== 1'b0 || cpu_dtack_n !== 1'b1 || mif.mem_req !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin failures++; $display("FAIL tmo_berr_hold got=changed exp=held"); end
        cpu_end();
        @(negedge clk);
        checks++;
        if (cpu_berr_n !== 1'b1) begin failures++; $display("FAIL tmo_berr_release got=%b exp=1", cpu_berr_n); end
        resp_en = 1'b1;
        repeat (2) @(negedge clk);
    endtask
`else
    task automatic test_no_timeout();
        bit bad;
        resp_en = 1'b0;
        cpu_start(22'h000500, 1'b1, 1'b0, 1'b0, 16'h0000);
        bad = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (cpu_berr_n !== 1'b1 || cpu_dtack_n !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin failures++; $display("FAIL notmo_berr got=asserted exp=berr_n=1"); end
        checks++;
        if (mif.mem_req !== 1'b1) begin failures++; $display("FAIL notmo_req_held got=%b exp=1", mif.mem_req); end
        reset = 1'b1;
        cpu_end();
        repeat (2) @(negedge clk);
        reset   = 1'b0;
        resp_en = 1'b1;
        repeat (2) @(negedge clk);
    endtask
`endif

    initial begin
        reset     = 1'b1;
        cpu_as_n  = 1'b1;
        cpu_cs    = 1'b0;
        cpu_rw    = 1'b1;
        cpu_uds_n = 1'b1;
        cpu_lds_n = 1'b1;
        cpu_addr  = '0;
        cpu_din   = '0;
        vid_req   = 1'b0;
        vid_addr  = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_cpu_read();
        test_cpu_write();
        test_vid_starvation();
        test_same_cycle();
        test_reset_mid_access();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
